// File: rtl/dp_pkg.sv
// Shared definitions for the MEM-stage data memory responder:
// access size encodings, FSM states and the alignment rule.
package dp_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // The reserved size 2'b11 falls into the word rule
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lane_mask.sv
// Big-endian lane selection shared by the store and load paths:
// byte enables, store-data positioning and load extract/extend.
module lane_mask
  import dp_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] word_in,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [4:0]  shift;
  logic [31:0] lane_data;

  // Offset 0 is the most significant lane, so the bit shift is (3-offset)*8 for bytes
  always_comb begin
    byte_en    = 4'b0000;
    store_word = '0;
    load_word  = '0;
    shift      = '0;
    lane_data  = '0;
    case (size)
      SZ_BYTE: begin
        shift      = {~offset, 3'b000};
        byte_en    = 4'b0001 << ~offset;
        store_word = {24'h0, store_data[7:0]} << shift;
        lane_data  = word_in >> shift;
        load_word  = {{24{~load_unsigned & lane_data[7]}}, lane_data[7:0]};
      end
      SZ_HALF: begin
        shift      = {~offset[1], 4'b0000};
        byte_en    = offset[1] ? 4'b0011 : 4'b1100;
        store_word = {16'h0, store_data[15:0]} << shift;
        lane_data  = word_in >> shift;
        load_word  = {{16{~load_unsigned & lane_data[15]}}, lane_data[15:0]};
      end
      default: begin
        byte_en    = 4'b1111;
        store_word = store_data;
        load_word  = word_in;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Sequential data-memory slave for the MEM stage: accepts one load/store,
// waits WAIT_CYCLES, then pulses Ready while Stall holds the pipeline.
module data_mem_responder
  import dp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Bytes2Access,
  input  logic        LoadUnsigned,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AddrError,
  output logic        Stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        read_q;
  logic        write_q;

  logic          req;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [1:0]    cur_size;
  logic          cur_unsigned;
  logic          cur_read;
  logic          cur_write;
  logic          cur_error;
  logic          go_resp;
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   store_word;
  logic [31:0]   load_word;
  logic          unused_addr_bits;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  assign req              = MemRead | MemWrite;
  assign unused_addr_bits = ^Address[31:AW+2];

  // With no wait states the access completes on the accept edge, so it must use the live inputs
  assign cur_addr     = (state == S_IDLE) ? Address[AW+1:0] : addr_q;
  assign cur_wdata    = (state == S_IDLE) ? WriteData       : wdata_q;
  assign cur_size     = (state == S_IDLE) ? Bytes2Access    : size_q;
  assign cur_unsigned = (state == S_IDLE) ? LoadUnsigned    : unsigned_q;
  assign cur_read     = (state == S_IDLE) ? MemRead         : read_q;
  assign cur_write    = (state == S_IDLE) ? MemWrite        : write_q;

  assign cur_error = is_misaligned(cur_size, cur_addr[1:0]) | (cur_read & cur_write);
  assign word_idx  = cur_addr[AW+1:2];
  assign go_resp   = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (wait_cnt == 4'd0));

  assign Stall = ((state == S_IDLE) && req) || (state == S_WAIT);

  lane_mask u_lane_mask (
    .offset        (cur_addr[1:0]),
    .size          (cur_size),
    .load_unsigned (cur_unsigned),
    .store_data    (cur_wdata),
    .word_in       (mem[word_idx]),
    .byte_en       (byte_en),
    .store_word    (store_word),
    .load_word     (load_word)
  );

  // Array is deliberately not reset; a store still pending when Rst rises is dropped
  always_ff @(posedge Clk) begin
    if (go_resp && cur_write && !cur_error && !Rst) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      Ready      <= 1'b0;
      AddrError  <= 1'b0;
      ReadData   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_WORD;
      unsigned_q <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      Ready     <= 1'b0;
      AddrError <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q     <= Address[AW+1:0];
            wdata_q    <= WriteData;
            size_q     <= Bytes2Access;
            unsigned_q <= LoadUnsigned;
            read_q     <= MemRead;
            write_q    <= MemWrite;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        Ready     <= 1'b1;
        AddrError <= cur_error;
        if (cur_error)     ReadData <= '0;
        else if (cur_read) ReadData <= load_word;
      end
    end
  end

endmodule
